// File: rtl/mux_tdm_lanes_if.sv
// Signal bundle of the TDM lane multiplexer: parallel lane side in, serial side out.
// master = lane source (drives data_in/valid_in), slave = the multiplexer.
interface mux_tdm_lanes_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  localparam int SLOT_W = $clog2(LANES);

  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [SLOT_W-1:0]      lane_out;
  logic                   frame_start;
  logic                   idle_out;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, lane_out, frame_start, idle_out
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, lane_out, frame_start, idle_out
  );
endinterface

// File: rtl/mux_tdm_lanes.sv
// Single-clock TDM multiplexer: serialises LANES parallel lane words, one per clk_4f cycle.
// Define MUX_TDM_IDLE_FILL_EN to drive IDLE_SYM (instead of zero) on slots without valid data.
module mux_tdm_lanes #(
  parameter int         LANES    = 4,      // power of two, 2..16
  parameter int         WIDTH    = 8,
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic           clk_4f,
  input  logic           reset,
  mux_tdm_lanes_if.slave bus
);
  localparam int                SLOT_W    = $clog2(LANES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);
  localparam logic [WIDTH+7:0]  SYM_EXT   = {{WIDTH{1'b0}}, IDLE_SYM};
`ifdef MUX_TDM_IDLE_FILL_EN
  localparam bit                FILL_EN   = 1'b1;
`else
  localparam bit                FILL_EN   = 1'b0;
`endif
  localparam logic [WIDTH-1:0]  FILL_WORD = FILL_EN ? SYM_EXT[WIDTH-1:0] : '0;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [WIDTH-1:0]  r_shadow_d [LANES];
  logic [LANES-1:0]  r_shadow_v;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_valid_out;
  logic [SLOT_W-1:0] r_lane_out;
  logic              r_frame_start;
  logic              r_idle_out;

  logic w_capture;
  logic w_slot_valid;

  assign w_capture    = (r_slot == LAST_SLOT);
  assign w_slot_valid = r_shadow_v[r_slot] && (r_state == ST_RUN);

  // State only changes on a capture edge, so a whole frame is emitted under one state.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_slot        <= '0;
      // NOTE: the shadow is reset as well, so no stale lane data can leak out after reset.
      for (int i = 0; i < LANES; i++) r_shadow_d[i] <= '0;
      r_shadow_v    <= '0;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
      r_lane_out    <= '0;
      r_frame_start <= 1'b0;
      r_idle_out    <= 1'b1;
    end else begin
      r_slot <= r_slot + SLOT_W'(1);

      // NOTE: non-blocking updates mean the output mux below still reads the previous
      // frame's shadow and state on the capture edge itself.
      if (w_capture) begin
        for (int i = 0; i < LANES; i++) r_shadow_d[i] <= bus.data_in[i*WIDTH +: WIDTH];
        r_shadow_v <= bus.valid_in;
        r_state    <= (|bus.valid_in) ? ST_RUN : ST_IDLE;
      end

      r_lane_out    <= r_slot;
      r_valid_out   <= w_slot_valid;
      r_data_out    <= w_slot_valid ? r_shadow_d[r_slot] : FILL_WORD;
      r_frame_start <= (r_state == ST_RUN) && (r_slot == '0);
      r_idle_out    <= (r_state == ST_IDLE);
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.lane_out    = r_lane_out;
  assign bus.frame_start = r_frame_start;
  assign bus.idle_out    = r_idle_out;
endmodule

// File: tb/tb_mux_tdm_lanes.sv
// Scoreboard bench for mux_tdm_lanes: directed 4x8 instance plus random 8x16 instance.
module tb_mux_tdm_lanes;
`ifdef MUX_TDM_IDLE_FILL_EN
  localparam logic [15:0] FILL_EXP = 16'h00BC;
`else
  localparam logic [15:0] FILL_EXP = 16'h0000;
`endif
  localparam logic [31:0] D1 = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [31:0] D2 = {8'h88, 8'h77, 8'h66, 8'h55};
  localparam logic [31:0] D3 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic [2:0]  lane;
    logic        fs;
    logic        idle;
  } exp_t;

  logic clk_4f = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_4f = ~clk_4f;

  mux_tdm_lanes_if #(.LANES(4), .WIDTH(8))  bus_a ();
  mux_tdm_lanes_if #(.LANES(8), .WIDTH(16)) bus_b ();

  mux_tdm_lanes #(.LANES(4), .WIDTH(8))  dut_a (.clk_4f(clk_4f), .reset(reset), .bus(bus_a));
  mux_tdm_lanes #(.LANES(8), .WIDTH(16)) dut_b (.clk_4f(clk_4f), .reset(reset), .bus(bus_b));

  exp_t q_a[$];
  exp_t q_b[$];
  int   slot_a = 0;
  int   slot_b = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output words for one captured frame, emitted on the LANES following edges.
  task automatic push_frame(input int dut, input logic [7:0] v, input logic [127:0] d);
    int   lanes;
    int   w;
    logic run;
    exp_t e;
    lanes = (dut == 0) ? 4 : 8;
    w     = (dut == 0) ? 8 : 16;
    run   = |v;
    for (int k = 0; k < lanes; k++) begin
      e.data = d[k*w +: 16];
      if (w == 8) e.data[15:8] = 8'h00;
      if (!v[k]) e.data = FILL_EXP;
      e.valid = v[k];
      e.lane  = 3'(k);
      e.fs    = run && (k == 0);
      e.idle  = !run;
      if (dut == 0) q_a.push_back(e);
      else          q_b.push_back(e);
    end
  endtask

  task automatic compare(input int dut);
    exp_t  e;
    exp_t  got;
    string n;
    int    pending;
    if (dut == 0) begin
      n = "A";
      got.data  = {8'h00, bus_a.data_out};
      got.valid = bus_a.valid_out;
      got.lane  = {1'b0, bus_a.lane_out};
      got.fs    = bus_a.frame_start;
      got.idle  = bus_a.idle_out;
      pending   = q_a.size();
    end else begin
      n = "B";
      got.data  = bus_b.data_out;
      got.valid = bus_b.valid_out;
      got.lane  = bus_b.lane_out;
      got.fs    = bus_b.frame_start;
      got.idle  = bus_b.idle_out;
      pending   = q_b.size();
    end
    check({n, ".pending"}, 32'(pending != 0), 32'd1);
    if (pending == 0) return;
    e = (dut == 0) ? q_a.pop_front() : q_b.pop_front();
    check($sformatf("%s.data[lane%0d]", n, e.lane),  32'(got.data),  32'(e.data));
    check($sformatf("%s.valid[lane%0d]", n, e.lane), 32'(got.valid), 32'(e.valid));
    check($sformatf("%s.lane_out", n),               32'(got.lane),  32'(e.lane));
    check($sformatf("%s.frame_start[lane%0d]", n, e.lane), 32'(got.fs), 32'(e.fs));
    check($sformatf("%s.idle_out[lane%0d]", n, e.lane), 32'(got.idle), 32'(e.idle));
  endtask

  task automatic check_reset();
    check("A.rst.data",  32'(bus_a.data_out),    32'd0);
    check("A.rst.valid", 32'(bus_a.valid_out),   32'd0);
    check("A.rst.lane",  32'(bus_a.lane_out),    32'd0);
    check("A.rst.fs",    32'(bus_a.frame_start), 32'd0);
    check("A.rst.idle",  32'(bus_a.idle_out),    32'd1);
    check("B.rst.data",  32'(bus_b.data_out),    32'd0);
    check("B.rst.valid", 32'(bus_b.valid_out),   32'd0);
    check("B.rst.idle",  32'(bus_b.idle_out),    32'd1);
  endtask

  // One clock: model the capture, sample outputs 1 time unit later, re-randomise B inputs.
  task automatic tick();
    @(posedge clk_4f);
    if (reset == 1'b0) begin
      if (slot_a == 3) push_frame(0, {4'h0, bus_a.valid_in}, {96'h0, bus_a.data_in});
      if (slot_b == 7) push_frame(1, bus_b.valid_in, bus_b.data_in);
      slot_a = (slot_a + 1) % 4;
      slot_b = (slot_b + 1) % 8;
    end
    #1;
    if (reset == 1'b1) begin
      check_reset();
    end else begin
      compare(0);
      compare(1);
    end
    bus_b.data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus_b.valid_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
  endtask

  task automatic run_until_capture_a();
    do tick(); while (slot_a != 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check_reset();
    q_a.delete();
    q_b.delete();
    slot_a = 0;
    slot_b = 0;
    repeat (cycles) tick();
    reset = 1'b0;
    push_frame(0, 8'h00, 128'h0);
    push_frame(1, 8'h00, 128'h0);
  endtask

  initial begin
    bus_a.data_in  = '0;
    bus_a.valid_in = '0;
    bus_b.data_in  = '0;
    bus_b.valid_in = '0;
    #2;
    do_reset(3);

    // Full frame, then a mixed frame with lanes 0 and 2 empty
    bus_a.data_in  = D1;
    bus_a.valid_in = 4'hF;
    run_until_capture_a();
    bus_a.valid_in = 4'b1010;
    run_until_capture_a();

    // Inputs disturbed between captures must never reach the output
    tick();
    bus_a.data_in  = 32'hA5A5_A5A5;
    bus_a.valid_in = 4'h5;
    tick();
    bus_a.data_in  = D2;
    bus_a.valid_in = 4'hF;
    run_until_capture_a();

    // Drop to idle, then restart traffic
    bus_a.valid_in = 4'h0;
    run_until_capture_a();
    run_until_capture_a();
    bus_a.data_in  = D1;
    bus_a.valid_in = 4'hF;
    run_until_capture_a();

    // Reset at slot 2 of a valid frame, new data captured after release
    tick();
    tick();
    bus_a.data_in = D3;
    do_reset(2);
    run_until_capture_a();
    bus_a.valid_in = 4'h0;
    run_until_capture_a();
    run_until_capture_a();

    // Random traffic on both instances
    repeat (40) begin
      bus_a.data_in  = $urandom();
      bus_a.valid_in = 4'($urandom());
      run_until_capture_a();
    end
    bus_a.valid_in = 4'h0;
    repeat (3) run_until_capture_a();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mux_tdm_lanes.md
# mux_tdm_lanes

Parametrised time-division lane multiplexer for the physical-layer transmit path. It replaces the fixed 4-lane, three-clock mux tree (clk_f → clk_2f → clk_4f) with a single-clock design. An internal slot counter serialises LANES parallel byte lanes onto one output word per clk_4f cycle. The block also generates the idle indication itself, so no separate idle generator is needed, and it carries a lane tag so the receive demux can realign.

## Interface
Parameters:
- LANES, 4, number of input lanes; power of two, 2..16
- WIDTH, 8, bits per lane word
- IDLE_SYM, 8'hBC, word driven on invalid slots when idle fill is compiled in; truncated or zero-extended to WIDTH

Ports:
- clk_4f  in  1  serial-rate clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- data_in  in  LANES*WIDTH  packed lane words; lane i = data_in[i*WIDTH +: WIDTH]
- valid_in  in  LANES  per-lane valid; bit i qualifies lane i
- data_out  out  WIDTH  serialised word
- valid_out  out  1  data_out carries a valid lane word
- lane_out  out  log2(LANES)  lane index of current data_out
- frame_start  out  1  high while lane_out==0 in RUN
- idle_out  out  1  link idle (state IDLE)

## Operation
- slot: log2(LANES)-bit counter; increments every cycle and wraps LANES-1→0. Free-running and never gated.
- Capture: on the edge where slot==LANES-1, data_in/valid_in are loaded into the shadow registers (shadow_d, shadow_v). The value read from shadow on that same edge is the old content, using non-blocking semantics.
- Output register: every edge, lane_out←slot, data_out←shadow_d[slot], valid_out←shadow_v[slot] & (state==RUN).
- FSM, two states:
  - IDLE (reset state): idle_out=1, valid_out=0, frame_start=0.
  - IDLE→RUN: on a capture edge where the captured valid_in is non-zero.
  - RUN→IDLE: on a capture edge where the captured valid_in is all zero.
  - The state change takes effect for the frame being emitted from that capture onward, so frames are never split across states.
- Mixed frames in RUN: lanes with valid=0 still occupy their slot, with valid_out=0. data_out for such slots follows Configuration.
- Inputs are sampled only at capture; changes at any other time are ignored.
- Reset values: slot=0, shadow=0, data_out=0, valid_out=0, lane_out=0, frame_start=0, idle_out=1, state=IDLE.

## Timing
- Frame period: LANES cycles.
- Latency: lane k, captured at edge E, appears on data_out after edge E+1+k, with lane_out=k. Lane 0 latency is 1 cycle after capture.
- The first capture after reset release is at the (LANES)th rising edge, when slot is LANES-1. The first output word follows on the next edge.
- frame_start and idle_out are registered and aligned with data_out, not combinational from slot.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). The partial frame is discarded. After release, the slot restarts from 0 and no stale shadow data is emitted.
- Valid toggling exactly on a capture edge: the value setup before that edge is the one captured.

## Configuration
- MUX_TDM_IDLE_FILL_EN defined: slots with valid_out=0 drive data_out=IDLE_SYM, in both IDLE state and invalid lanes in RUN.
- MUX_TDM_IDLE_FILL_EN undefined: those slots drive data_out=0.
- valid_out, idle_out and the FSM are identical in both builds.

## Test plan
- Reset hold 3 cycles, all valid_in=0 → data_out=0, valid_out=0, idle_out=1 throughout; with the macro defined, data_out=8'hBC from the first post-reset edge.
- LANES=4, data_in={8'h44,8'h33,8'h22,8'h11}, valid_in=4'hF at capture → data_out 11,22,33,44 on four consecutive cycles; lane_out 0,1,2,3; frame_start on the 11 word; idle_out falls with the 11 word.
- valid_in=4'b1010 with same data → lanes 0 and 2 have valid_out=0 and data_out=0 (8'hBC with macro); lanes 1 and 3 output 22 and 44 with valid_out=1.
- Data changed mid-frame (slot 1) → the emitted frame keeps the captured values; new values appear only in the next frame.
- Running traffic, then valid_in=0 at a capture → the current frame completes, then idle_out=1 and valid_out=0 from the next lane-0 slot.
- Assert reset at slot 2 of a valid frame → outputs cleared the same cycle; after release, the first output word is at edge LANES+1 with the new capture data.
- LANES=8, WIDTH=16 regression with random valid patterns → scoreboard matches the demux reconstruction for every valid lane word.
